// File: rtl/hazard_control_unit_if.sv
// Instruction-side inputs and decoded control outputs of the hazard control unit.
// The master drives instructions and hazard flags; the slave is the control unit.
interface hazard_control_unit_if #(
    parameter int CNT_W    = 3,
    parameter int ALU_OP_W = 6
);
    logic                instr_valid;
    logic [5:0]          opcode;
    logic [5:0]          funct;
    logic                is_alu_zero;
    logic                is_full_rnum1;
    logic                is_full_rnum2;

    logic                is_R_type;
    logic                is_I_type;
    logic                is_J_type;
    logic                is_write_from_mem;
    logic                is_write_reg;
    logic                is_write_mem;
    logic                is_load_PC;
    logic [1:0]          control_mux_for_PC;
    logic [ALU_OP_W-1:0] opcode_alu;
    logic                is_nop;
    logic                is_halted;
    logic [CNT_W-1:0]    stall_count;

    modport master (
        output instr_valid, opcode, funct, is_alu_zero, is_full_rnum1, is_full_rnum2,
        input  is_R_type, is_I_type, is_J_type, is_write_from_mem, is_write_reg,
               is_write_mem, is_load_PC, control_mux_for_PC, opcode_alu, is_nop,
               is_halted, stall_count
    );

    modport slave (
        input  instr_valid, opcode, funct, is_alu_zero, is_full_rnum1, is_full_rnum2,
        output is_R_type, is_I_type, is_J_type, is_write_from_mem, is_write_reg,
               is_write_mem, is_load_PC, control_mux_for_PC, opcode_alu, is_nop,
               is_halted, stall_count
    );
endinterface

// File: rtl/hazard_control_unit.sv
// Pipeline control unit: decodes instructions into registered control signals and
// inserts stall bubbles for data hazards and a flush bubble after taken branches/jumps.
module hazard_control_unit #(
    parameter int STALL_CYCLES = 2,
    parameter int CNT_W        = 3,
    parameter int ALU_OP_W     = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    hazard_control_unit_if.slave  bus
);

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_NOP  = 6'b111111;
    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_SUB  = 6'b100010;

    typedef enum logic [1:0] {RUN, STALL, FLUSH, HALT} state_t;

    typedef struct packed {
        logic       r_type;
        logic       i_type;
        logic       j_type;
        logic       write_from_mem;
        logic       write_reg;
        logic       write_mem;
        logic       load_pc;
        logic [1:0] pc_mux;
        logic [5:0] alu_op;
        logic       nop;
        logic       halted;
    } ctrl_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    ctrl_t            ctrl_n;
    logic             hazard;
    logic             redirect;

    function automatic ctrl_t bubble(input logic load_pc);
        ctrl_t c;
        c         = '0;
        c.nop     = 1'b1;
        c.load_pc = load_pc;
        return c;
    endfunction

    function automatic ctrl_t halt_ctrl();
        ctrl_t c;
        c        = '0;
        c.halted = 1'b1;
        return c;
    endfunction

    function automatic logic is_known(input logic [5:0] op);
        return (op == OP_R)   || (op == OP_ADDI) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ) || (op == OP_J)    || (op == OP_NOP);
    endfunction

    // Every decoded instruction keeps fetching; only listed controls are raised.
    function automatic ctrl_t decode(input logic [5:0] op, input logic [5:0] fn,
                                     input logic zero);
        ctrl_t c;
        c         = '0;
        c.load_pc = 1'b1;
        case (op)
            OP_R: begin
                c.r_type    = 1'b1;
                c.write_reg = 1'b1;
                c.alu_op    = (fn == FN_ADD || fn == FN_SUB) ? fn : 6'b000000;
            end
            OP_ADDI: begin
                c.i_type    = 1'b1;
                c.write_reg = 1'b1;
                c.alu_op    = FN_ADD;
            end
            OP_LW: begin
                c.i_type         = 1'b1;
                c.write_from_mem = 1'b1;
                c.write_reg      = 1'b1;
                c.alu_op         = FN_ADD;
            end
            OP_SW: begin
                c.i_type    = 1'b1;
                c.write_mem = 1'b1;
                c.alu_op    = FN_ADD;
            end
            OP_BEQ: begin
                c.i_type = 1'b1;
                c.pc_mux = zero ? 2'b01 : 2'b00;
            end
            OP_J: begin
                c.j_type = 1'b1;
                c.pc_mux = 2'b10;
            end
            OP_NOP:  c.nop = 1'b1;
            default: c = '0;
        endcase
        return c;
    endfunction

    assign hazard   = bus.instr_valid &&
                      (bus.is_full_rnum1 || (bus.is_full_rnum2 && bus.opcode == OP_R));
    assign redirect = (bus.opcode == OP_J) || (bus.opcode == OP_BEQ && bus.is_alu_zero);

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        ctrl_n  = bubble(1'b1);
        case (state)
            RUN: begin
                if (bus.instr_valid && !is_known(bus.opcode)) begin
                    state_n = HALT;
                    ctrl_n  = halt_ctrl();
                end else if (hazard) begin
                    ctrl_n  = bubble(1'b0);
                    cnt_n   = CNT_W'(STALL_CYCLES - 1);
                    state_n = STALL;
                end else if (bus.instr_valid) begin
                    ctrl_n  = decode(bus.opcode, bus.funct, bus.is_alu_zero);
                    state_n = redirect ? FLUSH : RUN;
                end
            end
            STALL: begin
                // The last stall cycle issues the held instruction without rechecking
                // the hazard flags, so a persistent flag cannot stall forever.
                if (cnt != '0) begin
                    ctrl_n = bubble(1'b0);
                    cnt_n  = cnt - CNT_W'(1);
                end else if (!bus.instr_valid) begin
                    state_n = RUN;
                end else if (!is_known(bus.opcode)) begin
                    state_n = HALT;
                    ctrl_n  = halt_ctrl();
                end else begin
                    ctrl_n  = decode(bus.opcode, bus.funct, bus.is_alu_zero);
                    state_n = redirect ? FLUSH : RUN;
                end
            end
            FLUSH:   state_n = RUN;
            HALT:    ctrl_n  = halt_ctrl();
            default: state_n = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state                  <= RUN;
            cnt                    <= '0;
            bus.is_R_type          <= 1'b0;
            bus.is_I_type          <= 1'b0;
            bus.is_J_type          <= 1'b0;
            bus.is_write_from_mem  <= 1'b0;
            bus.is_write_reg       <= 1'b0;
            bus.is_write_mem       <= 1'b0;
            bus.is_load_PC         <= 1'b1;
            bus.control_mux_for_PC <= 2'b00;
            bus.opcode_alu         <= '0;
            bus.is_nop             <= 1'b0;
            bus.is_halted          <= 1'b0;
            bus.stall_count        <= '0;
        end else begin
            state                  <= state_n;
            cnt                    <= cnt_n;
            bus.is_R_type          <= ctrl_n.r_type;
            bus.is_I_type          <= ctrl_n.i_type;
            bus.is_J_type          <= ctrl_n.j_type;
            bus.is_write_from_mem  <= ctrl_n.write_from_mem;
            bus.is_write_reg       <= ctrl_n.write_reg;
            bus.is_write_mem       <= ctrl_n.write_mem;
            bus.is_load_PC         <= ctrl_n.load_pc;
            bus.control_mux_for_PC <= ctrl_n.pc_mux;
            bus.opcode_alu         <= ALU_OP_W'(ctrl_n.alu_op);
            bus.is_nop             <= ctrl_n.nop;
            bus.is_halted          <= ctrl_n.halted;
            bus.stall_count        <= (state_n == STALL) ? cnt_n : '0;
        end
    end

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed-vector bench for hazard_control_unit; expected control words are hand-computed
// and packed as {R,I,J,wfm,wreg,wmem,loadPC,mux[1:0],alu[5:0],nop,halted,stall[2:0]}.
module tb_hazard_control_unit;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    hazard_control_unit_if #(.CNT_W(3), .ALU_OP_W(6)) bus ();

    hazard_control_unit #(.STALL_CYCLES(2), .CNT_W(3), .ALU_OP_W(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    localparam logic [5:0] OP_R = 6'b000000, OP_ADDI = 6'b001000, OP_LW = 6'b100011,
                           OP_SW = 6'b101011, OP_BEQ = 6'b000100, OP_J = 6'b000010,
                           OP_NOP = 6'b111111, OP_BAD = 6'b110011;

    function automatic logic [19:0] cw(input logic r, i, j, wfm, wreg, wmem, lpc,
                                       input logic [1:0] mux, input logic [5:0] alu,
                                       input logic nop, halt, input logic [2:0] sc);
        return {r, i, j, wfm, wreg, wmem, lpc, mux, alu, nop, halt, sc};
    endfunction

    function automatic logic [19:0] observed_word();
        return {bus.is_R_type, bus.is_I_type, bus.is_J_type, bus.is_write_from_mem,
                bus.is_write_reg, bus.is_write_mem, bus.is_load_PC, bus.control_mux_for_PC,
                bus.opcode_alu, bus.is_nop, bus.is_halted, bus.stall_count};
    endfunction

    logic [19:0] w_reset, w_add, w_sub, w_and, w_addi, w_lw, w_sw, w_nop, w_bub_ld, w_halt;

    // Drive one instruction, clock it in, then settle past the edge before sampling.
    task automatic applyStimulus(input logic valid, input logic [5:0] op, input logic [5:0] fn,
                                 input logic zero, input logic f1, input logic f2);
        bus.instr_valid   = valid;
        bus.opcode        = op;
        bus.funct         = fn;
        bus.is_alu_zero   = zero;
        bus.is_full_rnum1 = f1;
        bus.is_full_rnum2 = f2;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    initial begin
        w_reset  = cw(0,0,0,0,0,0,1,2'b00,6'h00,0,0,3'd0);
        w_add    = cw(1,0,0,0,1,0,1,2'b00,6'h20,0,0,3'd0);
        w_sub    = cw(1,0,0,0,1,0,1,2'b00,6'h22,0,0,3'd0);
        w_and    = cw(1,0,0,0,1,0,1,2'b00,6'h00,0,0,3'd0);
        w_addi   = cw(0,1,0,0,1,0,1,2'b00,6'h20,0,0,3'd0);
        w_lw     = cw(0,1,0,1,1,0,1,2'b00,6'h20,0,0,3'd0);
        w_sw     = cw(0,1,0,0,0,1,1,2'b00,6'h20,0,0,3'd0);
        w_nop    = cw(0,0,0,0,0,0,1,2'b00,6'h00,1,0,3'd0);
        w_bub_ld = cw(0,0,0,0,0,0,1,2'b00,6'h00,1,0,3'd0);
        w_halt   = cw(0,0,0,0,0,0,0,2'b00,6'h00,0,1,3'd0);

        $display("[TB] start");
        rst = 1'b1;
        applyStimulus(1, OP_R, 6'b100000, 0, 1, 1);
        applyStimulus(1, OP_R, 6'b100000, 0, 1, 1);
        checkOutput("reset", observed_word(), w_reset);
        rst = 1'b0;

        applyStimulus(1, OP_R, 6'b100000, 0, 0, 0);    checkOutput("add", observed_word(), w_add);
        applyStimulus(1, OP_R, 6'b100010, 0, 0, 0);    checkOutput("sub", observed_word(), w_sub);
        applyStimulus(1, OP_R, 6'b100100, 0, 0, 0);    checkOutput("r_other", observed_word(), w_and);
        applyStimulus(1, OP_ADDI, 6'h00, 0, 0, 0);     checkOutput("addi", observed_word(), w_addi);
        applyStimulus(1, OP_SW, 6'h00, 0, 0, 0);       checkOutput("sw", observed_word(), w_sw);
        applyStimulus(1, OP_NOP, 6'h00, 0, 0, 0);      checkOutput("nop", observed_word(), w_nop);
        applyStimulus(0, OP_R, 6'b100000, 0, 0, 0);    checkOutput("invalid", observed_word(), w_bub_ld);
        applyStimulus(1, OP_ADDI, 6'h00, 0, 0, 1);     checkOutput("rnum2_itype", observed_word(), w_addi);

        // Load-use hazard on rnum1: two held bubbles, then lw issues despite the flag.
        applyStimulus(1, OP_LW, 6'h00, 0, 1, 0);
        checkOutput("lw_stall1", observed_word(), cw(0,0,0,0,0,0,0,2'b00,6'h00,1,0,3'd1));
        applyStimulus(1, OP_LW, 6'h00, 0, 1, 0);
        checkOutput("lw_stall0", observed_word(), cw(0,0,0,0,0,0,0,2'b00,6'h00,1,0,3'd0));
        applyStimulus(1, OP_LW, 6'h00, 0, 1, 0);       checkOutput("lw_issue", observed_word(), w_lw);
        applyStimulus(1, OP_R, 6'b100000, 0, 0, 0);    checkOutput("after_lw", observed_word(), w_add);

        applyStimulus(1, OP_R, 6'b100010, 0, 0, 1);
        checkOutput("r2_stall1", observed_word(), cw(0,0,0,0,0,0,0,2'b00,6'h00,1,0,3'd1));
        applyStimulus(1, OP_R, 6'b100010, 0, 0, 1);
        checkOutput("r2_stall0", observed_word(), cw(0,0,0,0,0,0,0,2'b00,6'h00,1,0,3'd0));
        applyStimulus(1, OP_R, 6'b100010, 0, 0, 1);    checkOutput("r2_issue", observed_word(), w_sub);

        applyStimulus(1, OP_BEQ, 6'h00, 1, 0, 0);
        checkOutput("beq_taken", observed_word(), cw(0,1,0,0,0,0,1,2'b01,6'h00,0,0,3'd0));
        applyStimulus(1, OP_R, 6'b100000, 0, 0, 0);    checkOutput("beq_flush", observed_word(), w_bub_ld);
        applyStimulus(1, OP_R, 6'b100000, 0, 0, 0);    checkOutput("beq_resume", observed_word(), w_add);
        applyStimulus(1, OP_BEQ, 6'h00, 0, 0, 0);
        checkOutput("beq_not", observed_word(), cw(0,1,0,0,0,0,1,2'b00,6'h00,0,0,3'd0));
        applyStimulus(1, OP_R, 6'b100000, 0, 0, 0);    checkOutput("beq_noflush", observed_word(), w_add);

        applyStimulus(1, OP_J, 6'h00, 0, 0, 0);
        checkOutput("jump", observed_word(), cw(0,0,1,0,0,0,1,2'b10,6'h00,0,0,3'd0));
        applyStimulus(1, OP_ADDI, 6'h00, 0, 0, 0);     checkOutput("j_flush", observed_word(), w_bub_ld);
        applyStimulus(0, OP_R, 6'h00, 0, 0, 0);        checkOutput("j_no_addi", observed_word(), w_bub_ld);

        // Reset in the middle of a stall abandons it.
        applyStimulus(1, OP_LW, 6'h00, 0, 1, 0);
        checkOutput("mid_stall1", observed_word(), cw(0,0,0,0,0,0,0,2'b00,6'h00,1,0,3'd1));
        rst = 1'b1;
        applyStimulus(1, OP_LW, 6'h00, 0, 1, 0);       checkOutput("stall_rst", observed_word(), w_reset);
        rst = 1'b0;
        applyStimulus(1, OP_R, 6'b100000, 0, 0, 0);    checkOutput("post_rst_add", observed_word(), w_add);

        applyStimulus(1, OP_BAD, 6'h00, 0, 0, 0);      checkOutput("halt_enter", observed_word(), w_halt);
        for (int k = 0; k < 10; k++) begin
            applyStimulus(k[0], (k[1] ? OP_J : OP_R), 6'b100000, k[2], k[0], k[1]);
            checkOutput($sformatf("halt_hold%0d", k), observed_word(), w_halt);
        end
        rst = 1'b1;
        applyStimulus(1, OP_R, 6'b100000, 0, 0, 0);    checkOutput("halt_rst", observed_word(), w_reset);
        rst = 1'b0;
        applyStimulus(1, OP_ADDI, 6'h00, 0, 0, 0);     checkOutput("post_halt", observed_word(), w_addi);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_control_unit.md
HAZARD_CONTROL_UNIT -- requirements
Module: hazard_control_unit

Interface
REQ-001 The block SHALL have parameter STALL_CYCLES, default 2, giving the bubbles inserted per data hazard (legal 1..7).
REQ-002 The block SHALL have parameter CNT_W, default 3, giving the stall counter width (2^CNT_W > STALL_CYCLES-1).
REQ-003 The block SHALL have parameter ALU_OP_W, default 6, giving the ALU opcode width (at least 6).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have inputs instr_valid (1, instruction present), opcode (6), funct (6), is_alu_zero (1), is_full_rnum1 (1) and is_full_rnum2 (1), the last two being pending-write hazard flags for source registers 1 and 2.
REQ-007 The block SHALL have 1-bit outputs is_R_type, is_I_type, is_J_type, is_write_from_mem, is_write_reg, is_write_mem and is_load_PC.
REQ-008 The block SHALL have outputs control_mux_for_PC (2 bits), opcode_alu (ALU_OP_W bits, zero-extended), is_nop (1, bubble issued), is_halted (1) and stall_count (CNT_W).

Function
REQ-009 All outputs SHALL be registered, reflecting the inputs sampled at the previous rising edge (latency 1 cycle).
REQ-010 The FSM SHALL have states RUN, STALL, FLUSH and HALT.
REQ-011 The decode table SHALL be:
- 000000 (R; funct 100000 = add, 100010 = sub, other funct gives ALU op 0): R=1, write_reg=1.
- 001000 (addi): I=1, write_reg=1, ALU op 100000.
- 100011 (lw): I=1, write_from_mem=1, write_reg=1, ALU op 100000.
- 101011 (sw): I=1, write_mem=1, ALU op 100000.
- 000100 (beq): I=1, PC mux 01 when is_alu_zero=1, else 00.
- 000010 (j): J=1, PC mux 10.
- 111111 (nop): all controls 0, is_nop=1.
- Decoded instructions not listed otherwise SHALL drive is_load_PC=1 and all other controls 0.
REQ-012 A bubble SHALL drive all type, write and mux outputs to 0, opcode_alu to 0 and is_nop to 1; is_load_PC SHALL be as stated per case.
REQ-013 A hazard SHALL be instr_valid AND (is_full_rnum1 OR (is_full_rnum2 AND opcode==000000)).
REQ-014 In RUN, the following priority SHALL apply, highest first:
- instr_valid with an opcode outside the table: go to HALT.
- hazard: bubble with is_load_PC=0, load counter with STALL_CYCLES-1, go to STALL.
- instr_valid=0: bubble with is_load_PC=1.
- otherwise: decode; on beq taken or j, go to FLUSH.
REQ-015 In STALL with counter>0, the block SHALL issue a bubble with is_load_PC=0 and decrement the counter.
REQ-016 In STALL with counter==0, the block SHALL decode the current instruction without a hazard check (no livelock) and go to RUN, or to FLUSH on beq taken or j.
REQ-017 Each hazard SHALL therefore insert exactly STALL_CYCLES bubbles.
REQ-018 FLUSH SHALL last exactly one cycle: bubble with is_load_PC=1, inputs ignored, wrong-path instruction discarded, return to RUN.
REQ-019 HALT SHALL drive is_halted=1, is_load_PC=0, all other controls 0 and is_nop=0, and SHALL be left only by rst.
REQ-020 stall_count SHALL equal the counter value in STALL and 0 in every other state.

Reset
REQ-021 With rst=1 at a rising edge, the block SHALL enter RUN, clear the counter, drive is_load_PC=1 and drive all other outputs to 0 (is_nop=0, is_halted=0).
REQ-022 rst SHALL take priority over every state, including mid-STALL, FLUSH and HALT.

Verification
REQ-023 Reset then add (opcode 000000, funct 100000), no hazard -> next cycle R=1, write_reg=1, opcode_alu=100000, is_load_PC=1.
REQ-024 STALL_CYCLES=2, lw with is_full_rnum1=1 -> two bubble cycles (is_load_PC=0, stall_count 1 then 0), then lw decoded with write_from_mem=1 even though the hazard is still asserted.
REQ-025 beq with is_alu_zero=1 -> PC mux 01, then one FLUSH bubble with is_load_PC=1; beq with is_alu_zero=0 -> PC mux 00 and no flush.
REQ-026 j followed by addi -> PC mux 10, then a bubble; the addi is never decoded.
REQ-027 opcode 110011 with instr_valid=1 -> is_halted=1 and is_load_PC=0 held for 10 cycles regardless of inputs; rst -> RUN outputs.
REQ-028 rst asserted mid-STALL -> next cycle is_load_PC=1, stall_count=0 and the following instruction decoded normally.
